// File: rtl/ldpc_frame_xor_accumulator_if.sv
// Word-stream handshake bundle for the LDPC frame XOR accumulator.
// Carries one input stream and one output stream, both valid/ready.
interface ldpc_frame_xor_accumulator_if #(
   parameter int unsigned WIDTH = 96
);
   logic [WIDTH-1:0] i_input_data;
   logic             i_input_valid;
   logic             o_input_ready;
   logic [WIDTH-1:0] o_output_data;
   logic             o_output_valid;
   logic             i_output_ready;
   logic             o_output_last;

   // Accumulator side
   modport slave (
      input  i_input_data,
      input  i_input_valid,
      output o_input_ready,
      output o_output_data,
      output o_output_valid,
      input  i_output_ready,
      output o_output_last
   );

   // Producer/consumer side
   modport master (
      output i_input_data,
      output i_input_valid,
      input  o_input_ready,
      input  o_output_data,
      input  o_output_valid,
      output i_output_ready,
      input  o_output_last
   );
endinterface

// File: rtl/ldpc_frame_xor_accumulator.sv
// XOR-accumulates NUM_FRAMES consecutive LENGTH-word frames into one sum frame.
// Two ping-pong banks: one fills while the other drains.
module ldpc_frame_xor_accumulator #(
   parameter int unsigned WIDTH      = 96,
   parameter int unsigned LENGTH     = 11,
   parameter int unsigned NUM_FRAMES = 2
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   ldpc_frame_xor_accumulator_if.slave   bus
);
   localparam int unsigned FW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int unsigned FF_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam logic [FW_W-1:0] FW_LAST = FW_W'(LENGTH - 1);
   localparam logic [FF_W-1:0] FF_LAST = FF_W'(NUM_FRAMES - 1);

   logic [WIDTH-1:0] bank_q [2][LENGTH];
   logic [WIDTH-1:0] bank_d [2][LENGTH];
   logic [1:0]       full_q, full_d;
   logic             fill_bank_q, fill_bank_d;
   logic             read_bank_q, read_bank_d;
   logic [FW_W-1:0]  fw_q, fw_d;
   logic [FF_W-1:0]  ff_q, ff_d;
   logic [FW_W-1:0]  rw_q, rw_d;

   logic in_ready_c;
   logic out_valid_c;
   logic in_fire_c;
   logic out_fire_c;

   // Handshake qualifiers; reset forces both sides idle
   assign in_ready_c  = !full_q[fill_bank_q] && !i_reset;
   assign out_valid_c = full_q[read_bank_q] && !i_reset;
   assign in_fire_c   = bus.i_input_valid && in_ready_c;
   assign out_fire_c  = out_valid_c && bus.i_output_ready;

   assign bus.o_input_ready  = in_ready_c;
   assign bus.o_output_valid = out_valid_c;
   assign bus.o_output_data  = out_valid_c ? bank_q[read_bank_q][rw_q] : '0;
   assign bus.o_output_last  = out_valid_c && (rw_q == FW_LAST);

   // Fill and drain bookkeeping; the two sides always touch different banks
   always_comb begin
      bank_d      = bank_q;
      full_d      = full_q;
      fill_bank_d = fill_bank_q;
      read_bank_d = read_bank_q;
      fw_d        = fw_q;
      ff_d        = ff_q;
      rw_d        = rw_q;

      if (in_fire_c) begin
         // First frame of a group overwrites, so no clear pass is needed
         if (ff_q == '0) begin
            bank_d[fill_bank_q][fw_q] = bus.i_input_data;
         end else begin
            bank_d[fill_bank_q][fw_q] = bank_q[fill_bank_q][fw_q] ^ bus.i_input_data;
         end
         if (fw_q == FW_LAST) begin
            fw_d = '0;
            if (ff_q == FF_LAST) begin
               ff_d                = '0;
               full_d[fill_bank_q] = 1'b1;
               fill_bank_d         = ~fill_bank_q;
            end else begin
               ff_d = ff_q + FF_W'(1);
            end
         end else begin
            fw_d = fw_q + FW_W'(1);
         end
      end

      if (out_fire_c) begin
         if (rw_q == FW_LAST) begin
            rw_d                = '0;
            full_d[read_bank_q] = 1'b0;
            read_bank_d         = ~read_bank_q;
         end else begin
            rw_d = rw_q + FW_W'(1);
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         full_q      <= '0;
         fill_bank_q <= 1'b0;
         read_bank_q <= 1'b0;
         fw_q        <= '0;
         ff_q        <= '0;
         rw_q        <= '0;
      end else begin
         full_q      <= full_d;
         fill_bank_q <= fill_bank_d;
         read_bank_q <= read_bank_d;
         fw_q        <= fw_d;
         ff_q        <= ff_d;
         rw_q        <= rw_d;
      end
   end

   // Bank storage is not reset; full flags guard against stale reads
   always_ff @(posedge i_clock) begin
      bank_q <= bank_d;
   end
endmodule
